// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run-control block: the run-control FSM state
// encoding and the default build constants used by run_clock_ctrl.
// No ports (package).
package run_ctrl_pkg;

  // Default configuration of run_clock_ctrl.
  localparam int DIV_DEFAULT        = 4;   // CLK cycles per CPU_CE in continuous mode
  localparam int DEB_CYCLES_DEFAULT = 8;   // stable samples before the step level flips
  localparam int CNT_W_DEFAULT      = 16;  // width of the CPU cycle counter

  // Divider width covers the full legal DIV range 1..65535.
  localparam int DIV_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CONT,
    STEP_ARM,
    STEP_REL,
    HALT
  } run_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a debounce counter for one raw,
// asynchronous push-button input.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   raw    in   raw bouncing button level (asynchronous)
//   level  out  debounced level
//   rise   out  one-cycle strobe in the first cycle level reads 1
//
// The counter advances only while the synchronized input disagrees with the
// debounced level; any agreement clears it, so a bounce restarts the wait.
module btn_debounce #(
  parameter int DEB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      // synchronizer stage 0 -> stage 1
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // debounce stage
      rise <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        // The DEB_CYCLES-th consecutive disagreeing sample flips the level.
        cnt   <= '0;
        level <= ~level;
        rise  <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/run_clock_ctrl.sv
// Run-control stage in front of the CPU core. Produces a one-CLK-wide CPU
// clock-enable (CPU_CE) either continuously (one pulse every DIV cycles) or
// once per debounced press of the step button, and stops for good when the
// CPU raises HALT_TAG.
//
// Ports:
//   CLK        in   system clock, rising edge
//   CLR        in   synchronous active-high reset, highest priority
//   G          in   mode switch: 1 = continuous, 0 = single-step (async)
//   STEP_BTN   in   raw bouncing step button (async, active-high)
//   HALT_TAG   in   CPU halt request (synchronous to CLK)
//   CPU_CE     out  registered one-cycle CPU clock-enable
//   HALTED     out  sticky halt status
//   CYCLE_CNT  out  number of CPU_CE pulses issued (wraps silently)
//   MODE_CONT  out  synchronized copy of G
//
// Optional build macro RUN_CLOCK_CTRL_BREAK_EN adds:
//   PC_IN      in   current CPU program counter
//   BRK_ADDR   in   breakpoint address
//   BRK_HIT    out  sticky: a pulse was issued while PC_IN == BRK_ADDR;
//                   from then on the block behaves as in single-step mode.
module run_clock_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DIV        = DIV_DEFAULT,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             G,
  input  logic             STEP_BTN,
  input  logic             HALT_TAG,
  output logic             CPU_CE,
  output logic             HALTED,
  output logic [CNT_W-1:0] CYCLE_CNT,
  output logic             MODE_CONT
`ifdef RUN_CLOCK_CTRL_BREAK_EN
  ,
  input  logic [15:0]      PC_IN,
  input  logic [15:0]      BRK_ADDR,
  output logic             BRK_HIT
`endif
);

  run_state_t       state;
  run_state_t       state_d;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_d;
  logic             ce_d;
  logic             g_sync_p0;
  logic             mode;
  logic             step_level;
  logic             step_rise;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_step_deb (
    .clk   (CLK),
    .rst   (CLR),
    .raw   (STEP_BTN),
    .level (step_level),
    .rise  (step_rise)
  );

`ifdef RUN_CLOCK_CTRL_BREAK_EN
  // A hit breakpoint pins the block into single-step until CLR.
  assign mode = MODE_CONT & ~BRK_HIT;
`else
  assign mode = MODE_CONT;
`endif

  always_comb begin
    state_d = state;
    div_d   = div;
    ce_d    = 1'b0;
    case (state)
      IDLE: begin
        div_d   = '0;
        state_d = mode ? CONT : STEP_ARM;
      end
      CONT: begin
        if (!mode) begin
          div_d   = '0;
          state_d = STEP_ARM;
        end else if (div == DIV_W'(DIV - 1)) begin
          div_d = '0;
          ce_d  = 1'b1;
        end else begin
          div_d = div + DIV_W'(1);
        end
      end
      STEP_ARM: begin
        if (mode) begin
          div_d   = '0;
          state_d = CONT;
        end else if (step_rise) begin
          ce_d    = 1'b1;
          state_d = STEP_REL;
        end
      end
      STEP_REL: begin
        if (mode) begin
          div_d   = '0;
          state_d = CONT;
        end else if (!step_level) begin
          state_d = STEP_ARM;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Halt overrides any pulse that would be issued at the same edge.
    if (HALT_TAG) begin
      state_d = HALT;
      ce_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= IDLE;
      div       <= '0;
      CPU_CE    <= 1'b0;
      HALTED    <= 1'b0;
      CYCLE_CNT <= '0;
      g_sync_p0 <= 1'b0;
      MODE_CONT <= 1'b0;
    end else begin
      // G synchronizer stage 0 -> stage 1 (MODE_CONT)
      g_sync_p0 <= G;
      MODE_CONT <= g_sync_p0;
      // FSM / output stage
      state     <= state_d;
      div       <= div_d;
      CPU_CE    <= ce_d;
      HALTED    <= HALTED | HALT_TAG;
      CYCLE_CNT <= CYCLE_CNT + CNT_W'(ce_d);
    end
  end

`ifdef RUN_CLOCK_CTRL_BREAK_EN
  always_ff @(posedge CLK) begin
    if (CLR) begin
      BRK_HIT <= 1'b0;
    end else if (ce_d && (PC_IN == BRK_ADDR)) begin
      BRK_HIT <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_run_clock_ctrl.sv
// Directed bench for run_clock_ctrl (DIV=4, DEB_CYCLES=8, CNT_W=4).
// Inputs change and outputs are sampled on the falling edge of CLK.
module tb_run_clock_ctrl;

  logic       clk;
  logic       CLR;
  logic       G;
  logic       STEP_BTN;
  logic       HALT_TAG;
  logic       CPU_CE;
  logic       HALTED;
  logic [3:0] CYCLE_CNT;
  logic       MODE_CONT;

  int checks = 0;
  int passes = 0;

  run_clock_ctrl #(
    .DIV        (4),
    .DEB_CYCLES (8),
    .CNT_W      (4)
  ) dut (
    .CLK       (clk),
    .CLR       (CLR),
    .G         (G),
    .STEP_BTN  (STEP_BTN),
    .HALT_TAG  (HALT_TAG),
    .CPU_CE    (CPU_CE),
    .HALTED    (HALTED),
    .CYCLE_CNT (CYCLE_CNT),
    .MODE_CONT (MODE_CONT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves CLR low at a falling edge; sample n is taken n falling edges later.
  task automatic do_reset(input logic g);
    G        = g;
    STEP_BTN = 1'b0;
    HALT_TAG = 1'b0;
    CLR      = 1'b1;
    repeat (3) tick();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    G        = 1'b1;
    STEP_BTN = 1'b1;
    HALT_TAG = 1'b0;
    CLR      = 1'b1;
    repeat (3) tick();
    checks++; if (CPU_CE !== 1'b0) $display("FAIL reset_ce: got %b expected 0", CPU_CE); else passes++;
    checks++; if (HALTED !== 1'b0) $display("FAIL reset_halted: got %b expected 0", HALTED); else passes++;
    checks++; if (CYCLE_CNT !== 4'd0) $display("FAIL reset_cnt: got %0d expected 0", CYCLE_CNT); else passes++;
    checks++; if (MODE_CONT !== 1'b0) $display("FAIL reset_mode: got %b expected 0", MODE_CONT); else passes++;
    STEP_BTN = 1'b0;
  endtask

  task automatic test_continuous();
    int   first = -1;
    int   pulses = 0;
    int   bad = 0;
    logic mc2 = 1'b0;
    logic exp_ce;
    do_reset(1'b1);
    for (int i = 1; i <= 23; i++) begin
      tick();
      if (i == 2) mc2 = MODE_CONT;
      exp_ce = (i >= 7) && (((i - 7) % 4) == 0);
      if (CPU_CE === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (CPU_CE !== exp_ce) bad++;
    end
    checks++; if (mc2 !== 1'b1) $display("FAIL cont_mode_latency: got %b expected 1", mc2); else passes++;
    checks++; if (first != 7) $display("FAIL cont_first_pulse: got cycle %0d expected 7", first); else passes++;
    checks++; if (bad != 0) $display("FAIL cont_pattern: got %0d wrong cycles expected 0", bad); else passes++;
    checks++; if (CYCLE_CNT !== 4'd5) $display("FAIL cont_cnt: got %0d expected 5", CYCLE_CNT); else passes++;
  endtask

  task automatic test_step_clean();
    int first = -1;
    int pulses = 0;
    int rel_pulses = 0;
    do_reset(1'b0);
    repeat (5) tick();
    for (int i = 0; i < 20; i++) begin
      STEP_BTN = 1'b1;
      tick();
      if (CPU_CE === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checks++; if (pulses != 1) $display("FAIL clean_pulses: got %0d expected 1", pulses); else passes++;
    checks++; if (first != 10) $display("FAIL clean_latency: got sample %0d expected 10", first); else passes++;
    checks++; if (CYCLE_CNT !== 4'd1) $display("FAIL clean_cnt: got %0d expected 1", CYCLE_CNT); else passes++;
    STEP_BTN = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (CPU_CE === 1'b1) rel_pulses++;
    end
    checks++; if (rel_pulses != 0) $display("FAIL clean_release_pulses: got %0d expected 0", rel_pulses); else passes++;
    checks++; if (CYCLE_CNT !== 4'd1) $display("FAIL clean_release_cnt: got %0d expected 1", CYCLE_CNT); else passes++;
  endtask

  task automatic test_step_bouncy();
    int first = -1;
    int pulses = 0;
    int bounce_pulses = 0;
    for (int i = 0; i < 35; i++) begin
      if (i >= 12) STEP_BTN = 1'b1;
      else STEP_BTN = (((i / 3) % 2) == 0) ? 1'b1 : 1'b0;
      tick();
      if (CPU_CE === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        if (i < 15) bounce_pulses++;
      end
    end
    checks++; if (bounce_pulses != 0) $display("FAIL bouncy_during_bounce: got %0d expected 0", bounce_pulses); else passes++;
    checks++; if (pulses != 1) $display("FAIL bouncy_pulses: got %0d expected 1", pulses); else passes++;
    checks++; if (first != 22) $display("FAIL bouncy_latency: got sample %0d expected 22", first); else passes++;
    STEP_BTN = 1'b0;
    repeat (15) tick();
    checks++; if (CYCLE_CNT !== 4'd2) $display("FAIL bouncy_cnt: got %0d expected 2", CYCLE_CNT); else passes++;
  endtask

  task automatic test_halt_collision();
    int pulses = 0;
    int late = 0;
    do_reset(1'b1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (CPU_CE === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) $display("FAIL halt_pre_pulses: got %0d expected 1", pulses); else passes++;
    // Divider is at DIV-1 now: this edge would otherwise issue a pulse.
    HALT_TAG = 1'b1;
    tick();
    checks++; if (CPU_CE !== 1'b0) $display("FAIL halt_collision_ce: got %b expected 0", CPU_CE); else passes++;
    checks++; if (HALTED !== 1'b1) $display("FAIL halt_latch: got %b expected 1", HALTED); else passes++;
    HALT_TAG = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (CPU_CE === 1'b1) late++;
    end
    checks++; if (late != 0) $display("FAIL halt_no_pulses: got %0d expected 0", late); else passes++;
    checks++; if (HALTED !== 1'b1) $display("FAIL halt_sticky: got %b expected 1", HALTED); else passes++;
    checks++; if (CYCLE_CNT !== 4'd1) $display("FAIL halt_cnt: got %0d expected 1", CYCLE_CNT); else passes++;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    checks++; if (HALTED !== 1'b0) $display("FAIL halt_clr_halted: got %b expected 0", HALTED); else passes++;
    checks++; if (CYCLE_CNT !== 4'd0) $display("FAIL halt_clr_cnt: got %0d expected 0", CYCLE_CNT); else passes++;
  endtask

  task automatic test_mode_switch();
    int   sw_pulses = 0;
    int   idle_pulses = 0;
    int   pulses = 0;
    int   first = -1;
    logic mc10 = 1'b1;
    do_reset(1'b1);
    repeat (8) tick();
    G = 1'b0;
    for (int i = 9; i <= 11; i++) begin
      tick();
      if (i == 10) mc10 = MODE_CONT;
      if (CPU_CE === 1'b1) sw_pulses++;
    end
    checks++; if (sw_pulses != 0) $display("FAIL switch_no_ce: got %0d expected 0", sw_pulses); else passes++;
    checks++; if (mc10 !== 1'b0) $display("FAIL switch_mode: got %b expected 0", mc10); else passes++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (CPU_CE === 1'b1) idle_pulses++;
    end
    checks++; if (idle_pulses != 0) $display("FAIL switch_idle: got %0d expected 0", idle_pulses); else passes++;
    for (int i = 0; i < 20; i++) begin
      STEP_BTN = 1'b1;
      tick();
      if (CPU_CE === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checks++; if (pulses != 1) $display("FAIL switch_press_pulses: got %0d expected 1", pulses); else passes++;
    checks++; if (first != 10) $display("FAIL switch_press_latency: got sample %0d expected 10", first); else passes++;
    checks++; if (CYCLE_CNT !== 4'd2) $display("FAIL switch_cnt: got %0d expected 2", CYCLE_CNT); else passes++;
    STEP_BTN = 1'b0;
    repeat (15) tick();
  endtask

  task automatic test_wrap();
    int         pulses = 0;
    int         n = 0;
    logic [3:0] c15 = 4'bx;
    logic [3:0] c16 = 4'bx;
    logic [3:0] c17 = 4'bx;
    do_reset(1'b1);
    while (pulses < 17 && n < 200) begin
      tick();
      n++;
      if (CPU_CE === 1'b1) begin
        pulses++;
        if (pulses == 15) c15 = CYCLE_CNT;
        if (pulses == 16) c16 = CYCLE_CNT;
        if (pulses == 17) c17 = CYCLE_CNT;
      end
    end
    checks++; if (pulses != 17) $display("FAIL wrap_budget: got %0d pulses expected 17", pulses); else passes++;
    checks++; if (c15 !== 4'd15) $display("FAIL wrap_15: got %0d expected 15", c15); else passes++;
    checks++; if (c16 !== 4'd0) $display("FAIL wrap_16: got %0d expected 0", c16); else passes++;
    checks++; if (c17 !== 4'd1) $display("FAIL wrap_17: got %0d expected 1", c17); else passes++;
  endtask

  initial begin
    CLR      = 1'b1;
    G        = 1'b0;
    STEP_BTN = 1'b0;
    HALT_TAG = 1'b0;
    tick();
    test_reset();
    test_continuous();
    test_step_clean();
    test_step_bouncy();
    test_halt_collision();
    test_mode_switch();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
